// File: rtl/suma_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding and
// the default operand width.
package suma_pkg;

  // Controller states of the bit-serial adder
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } suma_state_t;

  // Default operand width in bits
  localparam int SUMA_N = 4;

endpackage

// File: rtl/suma_1bit.sv
// 1-bit full adder: So = A xor B xor Ci, Co = majority(A, B, Ci).
module suma_1bit (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Co,
  output logic So
);

  // Purely combinational sum and carry of three input bits
  always_comb begin
    So = A ^ B ^ Ci;
    Co = (A & B) | (Ci & (A ^ B));
  end

endmodule

// File: rtl/suma_serial_nbit.sv
// Bit-serial N-bit adder. Operands are captured on a start pulse, then one
// bit per clock (LSB first) goes through a single full adder whose carry is
// kept in a flip-flop. The complete sum and carry-out appear together with a
// one-cycle done pulse; S/Co never show partial results.
module suma_serial_nbit
  import suma_pkg::*;
#(
  parameter int N = SUMA_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Co
);

  // Counter is at least one bit wide so N=1 still has a valid "last bit" value
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  suma_state_t   r_state;
  suma_state_t   w_stateNext;
  logic          w_accept;
  logic          w_lastBit;

  logic [N-1:0]  r_aSh;
  logic [N-1:0]  r_bSh;
  logic [N-1:0]  r_sSh;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_s;
  logic          r_co;

  logic          w_so;
  logic          w_co;
  logic [N-1:0]  w_sShNext;

  // The single full adder works on the current LSBs and the stored carry
  suma_1bit u_suma_1bit (
    .A  (r_aSh[0]),
    .B  (r_bSh[0]),
    .Ci (r_carry),
    .Co (w_co),
    .So (w_so)
  );

  // New sum bit enters at the MSB; after N shifts the LSB of the result sits at bit 0
  assign w_sShNext = N'({w_so, r_sSh} >> 1);
  assign w_lastBit = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; a new operation is accepted from IDLE or straight out of DONE
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = ST_RUN;
        end else begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN edge, publish on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_sSh   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
    end else if (w_accept) begin
      r_aSh   <= A;
      r_bSh   <= B;
      r_sSh   <= '0;
      r_carry <= Ci;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_aSh   <= r_aSh >> 1;
      r_bSh   <= r_bSh >> 1;
      r_sSh   <= w_sShNext;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_lastBit) begin
        r_s  <= w_sShNext;
        r_co <= w_co;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign S    = r_s;
  assign Co   = r_co;

endmodule

// File: tb/tb_suma_serial_nbit.sv
// Self-checking bench for suma_serial_nbit: a 4-bit instance for directed and
// random operations and a 1-bit instance for the full-adder truth table.
// Expected results come from plain integer addition A + B + Ci.
module tb_suma_serial_nbit;

  logic       clk;
  logic       rst_n;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       ci4;
  logic       busy4;
  logic       done4;
  logic [3:0] s4;
  logic       co4;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       ci1;
  logic       busy1;
  logic       done1;
  logic [0:0] s1;
  logic       co1;

  int checks;
  int errors;
  int lastSum4;

  suma_serial_nbit #(.N(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .A     (a4),
    .B     (b4),
    .Ci    (ci4),
    .busy  (busy4),
    .done  (done4),
    .S     (s4),
    .Co    (co4)
  );

  suma_serial_nbit #(.N(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Ci    (ci1),
    .busy  (busy1),
    .done  (done1),
    .S     (s1),
    .Co    (co1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one 4-bit addition; optionally start straight from the current DONE cycle,
  // or keep start high and scramble operands while the adder is running
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic ci,
                               input bit backToBack, input bit disturb);
    int expSum;
    int edges;
    int busyCnt;
    expSum = int'(a) + int'(b) + int'(ci);
    if (!backToBack) @(negedge clk);
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    ci4    = ci;
    @(negedge clk);
    edges   = 1;
    busyCnt = 0;
    if (disturb) begin
      a4  = 4'd0;
      b4  = 4'd0;
      ci4 = 1'b0;
    end else begin
      start4 = 1'b0;
    end
    checkOutput("busyFirstRun", 32'(busy4), 32'd1);
    checkOutput("sHeldDuringRun", 32'(s4), 32'(lastSum4 & 15));
    while (!done4 && edges < 20) begin
      if (busy4) busyCnt++;
      if (edges >= 3) start4 = 1'b0;
      @(negedge clk);
      edges++;
    end
    start4 = 1'b0;
    checkOutput("doneLatency", 32'(edges), 32'd5);
    checkOutput("busyCycles", 32'(busyCnt), 32'd4);
    checkOutput("sumS", 32'(s4), 32'(expSum & 15));
    checkOutput("sumCo", 32'(co4), 32'((expSum >> 4) & 1));
    lastSum4 = expSum;
  endtask

  // After a done pulse without a new start the adder must be idle with results held
  task automatic checkIdle();
    @(negedge clk);
    checkOutput("donePulseWidth", 32'(done4), 32'd0);
    checkOutput("idleBusy", 32'(busy4), 32'd0);
    checkOutput("idleHoldS", 32'(s4), 32'(lastSum4 & 15));
  endtask

  // One full-adder case on the 1-bit instance
  task automatic applyStimulusN1(input logic a, input logic b, input logic ci);
    int expSum;
    int edges;
    expSum = int'(a) + int'(b) + int'(ci);
    @(negedge clk);
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    ci1    = ci;
    @(negedge clk);
    start1 = 1'b0;
    edges  = 1;
    while (!done1 && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("n1Latency", 32'(edges), 32'd2);
    checkOutput("n1Sum", 32'({co1, s1}), 32'(expSum));
    @(negedge clk);
    checkOutput("n1DoneWidth", 32'(done1), 32'd0);
  endtask

  // Main stimulus sequence
  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    bit         nextB2b;
    logic [2:0] combo;
    checks   = 0;
    errors   = 0;
    lastSum4 = 0;
    rst_n    = 1'b0;
    start4   = 1'b0;
    a4       = '0;
    b4       = '0;
    ci4      = 1'b0;
    start1   = 1'b0;
    a1       = '0;
    b1       = '0;
    ci1      = 1'b0;

    #12;
    checkOutput("rstS", 32'(s4), 32'd0);
    checkOutput("rstCo", 32'(co4), 32'd0);
    checkOutput("rstBusy", 32'(busy4), 32'd0);
    checkOutput("rstDone", 32'(done4), 32'd0);
    checkOutput("rstN1", 32'({busy1, done1, co1, s1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0);
    checkIdle();
    applyStimulus(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
    checkIdle();
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    checkIdle();
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    checkIdle();
    applyStimulus(4'b1001, 4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0);
    checkIdle();

    // Asynchronous reset in the second RUN cycle discards the operation
    @(negedge clk);
    start4 = 1'b1;
    a4     = 4'b1001;
    b4     = 4'b0110;
    ci4    = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstS", 32'(s4), 32'd0);
    checkOutput("midRstCo", 32'(co4), 32'd0);
    checkOutput("midRstBusy", 32'(busy4), 32'd0);
    checkOutput("midRstDone", 32'(done4), 32'd0);
    lastSum4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkIdle();

    // Random operations, sometimes chained back-to-back from the DONE cycle
    nextB2b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, nextB2b, 1'b0);
      nextB2b = ($urandom_range(0, 2) == 0);
      if (!nextB2b) checkIdle();
    end
    if (nextB2b) checkIdle();

    // Full truth table on the 1-bit adder
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      applyStimulusN1(combo[2], combo[1], combo[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
